// File: rtl/ps2_mouse_host.sv
// PS/2 host link layer: sends INIT_CMD after reset, waits for the 0xFA acknowledge,
// then decodes device frames into a byte/valid/error stream.
module ps2_mouse_host #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned INHIBIT_CYCLES = 1200,
    parameter int unsigned TIMEOUT_CYCLES = 24000,
    parameter int unsigned RETRY_CYCLES   = 240000,
    parameter logic [7:0]  INIT_CMD       = 8'hF4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    // "byte" is a reserved word, so the data port carries the _o suffix
    output logic [7:0] byte_o,
    output logic       valid,
    output logic       error,
    output logic       init_done
);

    localparam int unsigned FILT_W = $clog2(FILTER_LEN);
    localparam int unsigned CYC_MAX = (RETRY_CYCLES > INHIBIT_CYCLES) ? RETRY_CYCLES : INHIBIT_CYCLES;
    localparam int unsigned CYC_W  = $clog2(CYC_MAX);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_INHIBIT, S_REQ, S_TX, S_ACK, S_WAIT_RSP, S_BACKOFF, S_RUN
    } state_t;

    // index 0 = clock line, index 1 = data line
    logic [1:0]        sync1_q, sync2_q, flt_q;
    logic [FILT_W-1:0] fcnt_q [2];
    logic              clk_prev_q;
    logic              fall, sdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            flt_q      <= '1;
            fcnt_q[0]  <= '0;
            fcnt_q[1]  <= '0;
            clk_prev_q <= 1'b1;
        end else begin
            sync1_q    <= {ps2_data, ps2_clk};
            sync2_q    <= sync1_q;
            clk_prev_q <= flt_q[0];
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2_q[i] == flt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FILT_W'(FILTER_LEN - 1)) begin
                    flt_q[i]  <= sync2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + FILT_W'(1);
                end
            end
        end
    end

    assign fall  = clk_prev_q & ~flt_q[0];
    assign sdata = flt_q[1];

    state_t           state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic [9:0]       tx_sh_q, tx_sh_d;
    logic [7:0]       rx_sh_q, rx_sh_d, byte_q, byte_d;
    logic             par_q, par_d;
    logic             clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
    logic             valid_q, valid_d, err_q, err_d, init_q, init_d;
    logic             timeout, frame_end, frame_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_INHIBIT;
            cyc_q     <= '0;
            to_q      <= '0;
            bitcnt_q  <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            par_q     <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            init_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            to_q      <= to_d;
            bitcnt_q  <= bitcnt_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            par_q     <= par_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            init_q    <= init_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cyc_d     = '0;
        to_d      = '0;
        bitcnt_d  = bitcnt_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        par_d     = par_q;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        byte_d    = byte_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        init_d    = init_q;
        timeout   = 1'b0;
        frame_end = 1'b0;

        // a fall in the expiry cycle clears the counter and suppresses the timeout
        if (!fall && (bitcnt_q != 4'd0 || state_q == S_TX || state_q == S_ACK)) begin
            if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) timeout = 1'b1;
            else                                   to_d    = to_q + TO_W'(1);
        end

        if (fall && (state_q == S_WAIT_RSP || state_q == S_RUN)) begin
            case (bitcnt_q)
                4'd0:    if (!sdata) bitcnt_d = 4'd1;
                4'd9:    begin par_d = sdata; bitcnt_d = 4'd10; end
                4'd10:   begin frame_end = 1'b1; bitcnt_d = 4'd0; end
                default: begin rx_sh_d = {sdata, rx_sh_q[7:1]}; bitcnt_d = bitcnt_q + 4'd1; end
            endcase
        end
        frame_ok = (par_q == ~^rx_sh_q) && sdata;

        case (state_q)
            S_INHIBIT: begin
                clk_oe_d = 1'b1;
                bitcnt_d = '0;
                if (cyc_q == CYC_W'(INHIBIT_CYCLES - 1)) state_d = S_REQ;
                else                                     cyc_d   = cyc_q + CYC_W'(1);
            end
            S_REQ: begin
                clk_oe_d  = 1'b1;
                data_oe_d = 1'b1;
                tx_sh_d   = {1'b1, ~^INIT_CMD, INIT_CMD};
                bitcnt_d  = '0;
                state_d   = S_TX;
            end
            S_TX: begin
                data_oe_d = data_oe_q;
                if (fall) begin
                    data_oe_d = ~tx_sh_q[0];
                    tx_sh_d   = tx_sh_q >> 1;
                    if (bitcnt_q == 4'd9) begin
                        bitcnt_d = '0;
                        state_d  = S_ACK;
                    end else begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_BACKOFF;
                end
            end
            S_ACK: begin
                if (fall) begin
                    if (!sdata) begin
                        state_d = S_WAIT_RSP;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_BACKOFF;
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_BACKOFF;
                end
            end
            S_WAIT_RSP: begin
                if (frame_end) begin
                    if (frame_ok && rx_sh_q == 8'hFA) begin
                        init_d  = 1'b1;
                        state_d = S_RUN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_BACKOFF;
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_BACKOFF;
                end
            end
            S_BACKOFF: begin
                bitcnt_d = '0;
                if (cyc_q == CYC_W'(RETRY_CYCLES - 1)) state_d = S_INHIBIT;
                else                                   cyc_d   = cyc_q + CYC_W'(1);
            end
            S_RUN: begin
                if (frame_end) begin
                    if (frame_ok) begin
                        valid_d = 1'b1;
                        byte_d  = rx_sh_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (timeout) begin
                    err_d    = 1'b1;
                    bitcnt_d = '0;
                end
            end
            default: state_d = S_INHIBIT;
        endcase
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign byte_o      = byte_q;
    assign valid       = valid_q;
    assign error       = err_q;
    assign init_done   = init_q;

endmodule

// File: tb/tb_ps2_mouse_host.sv
// Bench for ps2_mouse_host: a PS/2 device model drives the wired-AND lines while a
// scoreboard monitor checks every valid/error strobe against queued expectations.
module tb_ps2_mouse_host;

    localparam int unsigned INH   = 100;
    localparam int unsigned TOUT  = 300;
    localparam int unsigned RETRY = 2000;
    localparam int unsigned H     = 25;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk, ps2_data, ps2_clk_oe, ps2_data_oe;
    logic       valid, error, init_done;
    logic [7:0] byte_o;

    assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data = ~(ps2_data_oe | dev_data_low);

    ps2_mouse_host #(
        .FILTER_LEN(8),
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TOUT),
        .RETRY_CYCLES(RETRY),
        .INIT_CMD(8'hF4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .byte_o(byte_o),
        .valid(valid),
        .error(error),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cycle_n = 0;
    int   err_cycle = 0;

    always @(posedge clk) cycle_n <= cycle_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (reset_n && (valid || error)) begin
            if (error) err_cycle = cycle_n;
            checks++;
            if (valid && error) begin
                failures++;
                $display("FAIL strobe_both valid=%b error=%b required one-hot", valid, error);
            end else if (expq.size() == 0) begin
                failures++;
                $display("FAIL strobe_unexpected valid=%b error=%b byte=%0h required none", valid, error, byte_o);
            end else begin
                mon_e = expq.pop_front();
                if (mon_e.is_err !== error || (!mon_e.is_err && byte_o !== mon_e.data)) begin
                    failures++;
                    $display("FAIL strobe_value error=%b byte=%0h required error=%b byte=%0h",
                             error, byte_o, mon_e.is_err, mon_e.data);
                end
            end
        end
    end

    task automatic cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic is_err, input logic [7:0] d);
        exp_t e;
        e.is_err = is_err;
        e.data   = d;
        expq.push_back(e);
    endtask

    task automatic dev_send(input logic [7:0] b, input logic flip, input int nbits, input int glitch);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            dev_data_low = ~fr[i];
            if (i == glitch) begin
                cyc(12);
                dev_clk_low = 1'b1;
                cyc(3);
                dev_clk_low = 1'b0;
                cyc(H - 15);
            end else begin
                cyc(H);
            end
            dev_clk_low = 1'b1;
            cyc(H);
            dev_clk_low = 1'b0;
        end
        dev_data_low = 1'b0;
        cyc(2 * H);
    endtask

    // host-to-device transfer; ack=1 pulls data low in the ack slot
    task automatic dev_recv(input logic ack, output logic [10:0] bits, output logic ok);
        int unsigned n;
        n = 0;
        ok = 1'b1;
        bits = '0;
        while (!(ps2_data_oe && !ps2_clk_oe) && n < 5000) begin
            cyc(1);
            n++;
        end
        if (n >= 5000) begin
            ok = 1'b0;
            return;
        end
        cyc(2 * H);
        bits[0] = ps2_data;
        for (int i = 1; i <= 10; i++) begin
            dev_clk_low = 1'b1;
            cyc(H);
            dev_clk_low = 1'b0;
            bits[i] = ps2_data;
            cyc(H);
        end
        dev_data_low = ack;
        cyc(H);
        dev_clk_low = 1'b1;
        cyc(H);
        dev_clk_low = 1'b0;
        cyc(H);
        dev_data_low = 1'b0;
        cyc(2 * H);
    endtask

    initial begin
        #600000;
        failures++;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] bits;
        logic        ok;
        int unsigned n;

        cyc(5);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        check("rst_byte", 32'(byte_o), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        reset_n = 1'b1;

        // first attempt: no acknowledge from the device
        push_exp(1'b1, 8'h00);
        dev_recv(1'b0, bits, ok);
        check("tx1_started", 32'(ok), 32'd1);
        check("tx1_bits", 32'(bits), 32'h5E8);
        n = 0;
        while (!ps2_clk_oe && n < 5000) begin
            cyc(1);
            n++;
        end
        check("backoff_reinhibit", 32'(ps2_clk_oe), 32'd1);
        check("backoff_len", 32'(cycle_n - err_cycle), 32'(RETRY + 1));
        check("init_done_after_nak", 32'(init_done), 32'd0);

        // device pulls clock during inhibit: ignored
        cyc(10);
        dev_clk_low = 1'b1;
        cyc(20);
        dev_clk_low = 1'b0;

        dev_recv(1'b1, bits, ok);
        check("tx2_started", 32'(ok), 32'd1);
        check("tx2_bits", 32'(bits), 32'h5E8);
        check("init_done_before_fa", 32'(init_done), 32'd0);
        dev_send(8'hFA, 1'b0, 11, -1);
        cyc(5);
        check("init_done", 32'(init_done), 32'd1);

        push_exp(1'b0, 8'h08); dev_send(8'h08, 1'b0, 11, -1);
        push_exp(1'b0, 8'h05); dev_send(8'h05, 1'b0, 11, -1);
        push_exp(1'b0, 8'hFD); dev_send(8'hFD, 1'b0, 11, -1);

        push_exp(1'b1, 8'h00); dev_send(8'h3C, 1'b1, 11, -1);
        push_exp(1'b0, 8'h10); dev_send(8'h10, 1'b0, 11, -1);

        push_exp(1'b1, 8'h00); dev_send(8'h99, 1'b0, 5, -1);
        cyc(TOUT + 100);
        push_exp(1'b0, 8'h22); dev_send(8'h22, 1'b0, 11, -1);

        push_exp(1'b0, 8'h55); dev_send(8'h55, 1'b0, 11, 4);

        cyc(20);
        check("init_done_held", 32'(init_done), 32'd1);
        check("scoreboard_drained", 32'(expq.size()), 32'd0);

        // reset asserted mid-transmit releases both lines without a clock edge
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        n = 0;
        while (!ps2_data_oe && n < 1000) begin
            cyc(1);
            n++;
        end
        check("retx_data_oe", 32'(ps2_data_oe), 32'd1);
        cyc(3);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("async_data_oe", 32'(ps2_data_oe), 32'd0);
        check("async_init_done", 32'(init_done), 32'd0);
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_host.md
Name: ps2_mouse_host

Overview:
- PS/2 host-side link layer for the QL mouse path; sits directly upstream of the QIMI mouse interface.
- Decodes device-to-host frames into a byte stream using the byte/valid/error protocol QIMI consumes.
- After reset, sends a single command byte, "enable data reporting" (0xF4), and waits for the device acknowledge before forwarding data.
- Drives the PS/2 lines open-collector: each output enable pulls its line low.

Parameters:
- FILTER_LEN, 8: consecutive equal synchronised samples required to change the filtered clk/data level.
- INHIBIT_CYCLES, 1200: clk cycles the host holds PS/2 clock low before a transmit (at least 100 us).
- TIMEOUT_CYCLES, 24000: maximum clk cycles between PS/2 clock falling edges inside a frame (about 2 ms).
- RETRY_CYCLES, 240000: back-off before the init sequence is retried.
- INIT_CMD, 8'hF4: command byte sent after reset.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous reset, active low
- ps2_clk  in  1  PS/2 clock line, raw
- ps2_data  in  1  PS/2 data line, raw
- ps2_clk_oe  out  1  1 = pull PS/2 clock low
- ps2_data_oe  out  1  1 = pull PS/2 data low
- byte  out  8  received data byte, valid only while valid=1
- valid  out  1  one-cycle strobe, good byte received
- error  out  1  one-cycle strobe, bad frame, timeout, or NAK
- init_done  out  1  high once the device has acknowledged INIT_CMD

Behaviour:
- Reset (asynchronous assert, synchronous release): ps2_clk_oe=0, ps2_data_oe=0, byte=0, valid=0, error=0, init_done=0; FSM enters INHIBIT; filter levels = 1.
- Input conditioning:
  - 2-FF synchroniser on each line, then FILTER_LEN glitch filter.
  - "fall" = filtered clock 1->0, one-cycle pulse. All bit actions occur on fall.
- FSM states and transitions:
  - INHIBIT: clk_oe=1 for INHIBIT_CYCLES.
  - REQ: data_oe=1, then clk_oe=0 on the following cycle.
  - TX: on each fall shift out the next bit. Order: 8 data bits LSB first, odd parity, then stop (data_oe=0). data_oe = !bit.
  - ACK: on the next fall, sample data. 0 -> WAIT_RSP. 1 -> error pulse, then BACKOFF.
  - WAIT_RSP: receive one frame. 0xFA -> RUN with init_done=1. Any other byte, framing fault, or timeout -> error pulse, then BACKOFF.
  - BACKOFF: wait RETRY_CYCLES, then INHIBIT.
  - RUN: receive forever; init_done stays 1 until reset.
- Receive frame (11 bits):
  - Bit order: start=0, d0..d7, odd parity, stop=1. Bit counter 0..10.
  - A start bit sampled as 1 is ignored (counter stays 0, no error).
  - The cycle after the stop-bit fall produces exactly one outcome:
    - parity and stop both correct: valid=1 with byte=data;
    - otherwise: error=1.
  - valid and error are never high together.
  - Latency: strobe is 1 clk after the stop-bit fall is detected.
  - byte holds its last value between strobes.
- Forwarding: valid is asserted only in RUN. The 0xFA ack in WAIT_RSP is consumed internally, never forwarded.
- Timeout:
  - Counter cleared on every fall; runs while bit counter != 0, or while in TX/ACK.
  - Reaching TIMEOUT_CYCLES in RUN: error pulse, bit counter to 0, stay in RUN.
  - Reaching TIMEOUT_CYCLES during init states: error pulse, then BACKOFF.
- Width rules:
  - Counters sized by $clog2 of the largest parameter they count to.
  - Parity computed as the XOR of the 8 data bits, inverted.
- Boundary cases:
  - Fall and timeout-expiry in the same cycle: the fall wins.
  - reset_n low mid-transmit: both oe outputs release within the same cycle (asynchronous).
  - The device pulling clock low during INHIBIT has no effect; the host already holds clock low.

Test Plan:
- Reset release, device model clocks in 0xF4 and acks, then sends 0xFA -> observed TX bits 0,0,0,1,0,1,1,1,1,parity=0,stop=1; init_done=1; no valid pulse for 0xFA.
- RUN, device sends frames 0x08, 0x05, 0xFD with correct parity -> three valid pulses with byte=0x08, 0x05, 0xFD in order; error stays 0.
- RUN, frame 0x3C with parity bit flipped -> single error pulse, no valid; next good frame 0x10 -> valid with byte=0x10.
- RUN, device stops after 5 bits for more than TIMEOUT_CYCLES -> one error pulse; next full frame 0x22 decodes correctly.
- Init: device leaves data high at ack slot -> error pulse; BACKOFF lasts RETRY_CYCLES; INHIBIT re-entered (clk_oe=1); second attempt acked with 0xFA -> init_done=1.
- 3-cycle glitch (FILTER_LEN=8) on ps2_clk in RUN -> no bit consumed; frame 0x55 still decoded correctly.
